// File: rtl/rf_pkg.sv
// Shared widths, write-buffer depth and command encoding for the
// register-file access controller.
package rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RD   = 2'b01,
    CMD_WR   = 2'b10
  } cmd_e;

endpackage

// File: rtl/rf_write_buffer.sv
// Circular write-back FIFO with two youngest-match address lookups used to
// forward buffered data that has not yet reached the register file.
module rf_write_buffer
  import rf_pkg::*;
#(
  parameter int DW    = RF_DATA_WIDTH,
  parameter int AW    = RF_ADDR_WIDTH,
  parameter int DEPTH = RF_WBUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  input  logic [AW-1:0]            lk1_addr_i,
  output logic                     lk1_hit_o,
  output logic [DW-1:0]            lk1_data_o,
  input  logic [AW-1:0]            lk2_addr_i,
  output logic                     lk2_hit_o,
  output logic [DW-1:0]            lk2_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Scan oldest to youngest so the last valid match wins.
  always_comb begin
    lk1_hit_o  = 1'b0;
    lk1_data_o = '0;
    lk2_hit_o  = 1'b0;
    lk2_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count_q) begin
        if (addr_q[rd_ptr_q + PW'(k)] == lk1_addr_i) begin
          lk1_hit_o  = 1'b1;
          lk1_data_o = data_q[rd_ptr_q + PW'(k)];
        end
        if (addr_q[rd_ptr_q + PW'(k)] == lk2_addr_i) begin
          lk2_hit_o  = 1'b1;
          lk2_data_o = data_q[rd_ptr_q + PW'(k)];
        end
      end
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Front-end sequencer for the dual-read register file: write buffering,
// one outstanding read pair, exclusive READ/WRITE control and forwarding.
//   state | meaning
//   IDLE  | no pending work; RF controls low, addresses hold
//   RD    | pending read issued to the RF, response captured at closing edge
//   WR    | head of the write buffer committed to the RF and popped
module rf_access_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int WBUF_DEPTH = RF_WBUF_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_VALID,
  output logic                  RD_READY,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR1,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR2,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA1,
  output logic [DATA_WIDTH-1:0] RSP_DATA2,
  output logic [1:0]            RSP_FWD,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_R1_ADDR,
  output logic [ADDR_WIDTH-1:0] RF_R2_ADDR,
  output logic [ADDR_WIDTH-1:0] RF_W_ADDR,
  output logic [DATA_WIDTH-1:0] RF_W_DATA,
  input  logic [DATA_WIDTH-1:0] RF_R1_DATA,
  input  logic [DATA_WIDTH-1:0] RF_R2_DATA
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  cmd_e                  cmd;
  logic [CW-1:0]         count;
  logic                  buf_full, wr_fire, rd_fire;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  hit1, hit2;
  logic [DATA_WIDTH-1:0] bdata1, bdata2;

  logic                  prd_valid_q, prd_valid_d;
  logic [ADDR_WIDTH-1:0] prd_a1_q, prd_a1_d, prd_a2_q, prd_a2_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d, rsp_data2_q, rsp_data2_d;
  logic [1:0]            rsp_fwd_q, rsp_fwd_d;
  logic [ADDR_WIDTH-1:0] r1_hold_q, r1_hold_d, r2_hold_q, r2_hold_d;
  logic [ADDR_WIDTH-1:0] w_addr_hold_q, w_addr_hold_d;
  logic [DATA_WIDTH-1:0] w_data_hold_q, w_data_hold_d;

  assign buf_full = (count == CW'(WBUF_DEPTH));
  assign WR_READY = !buf_full;
  assign RD_READY = !prd_valid_q;
  assign wr_fire  = WR_VALID && WR_READY;
  assign rd_fire  = RD_VALID && RD_READY;

  rf_write_buffer #(
    .DW   (DATA_WIDTH),
    .AW   (ADDR_WIDTH),
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (wr_fire),
    .push_addr_i(WR_ADDR),
    .push_data_i(WR_DATA),
    .pop_i      (cmd == CMD_WR),
    .count_o    (count),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .lk1_addr_i (prd_a1_q),
    .lk1_hit_o  (hit1),
    .lk1_data_o (bdata1),
    .lk2_addr_i (prd_a2_q),
    .lk2_hit_o  (hit2),
    .lk2_data_o (bdata2)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prd_valid_q   <= 1'b0;
      prd_a1_q      <= '0;
      prd_a2_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data1_q   <= '0;
      rsp_data2_q   <= '0;
      rsp_fwd_q     <= '0;
      r1_hold_q     <= '0;
      r2_hold_q     <= '0;
      w_addr_hold_q <= '0;
      w_data_hold_q <= '0;
    end else begin
      prd_valid_q   <= prd_valid_d;
      prd_a1_q      <= prd_a1_d;
      prd_a2_q      <= prd_a2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data1_q   <= rsp_data1_d;
      rsp_data2_q   <= rsp_data2_d;
      rsp_fwd_q     <= rsp_fwd_d;
      r1_hold_q     <= r1_hold_d;
      r2_hold_q     <= r2_hold_d;
      w_addr_hold_q <= w_addr_hold_d;
      w_data_hold_q <= w_data_hold_d;
    end
  end

  // A full buffer holds off the pending read so the drain always progresses.
  always_comb begin
    cmd = CMD_IDLE;
    if (prd_valid_q && !buf_full) cmd = CMD_RD;
    else if (count != '0)         cmd = CMD_WR;

    prd_valid_d   = prd_valid_q;
    prd_a1_d      = prd_a1_q;
    prd_a2_d      = prd_a2_q;
    rsp_valid_d   = 1'b0;
    rsp_data1_d   = rsp_data1_q;
    rsp_data2_d   = rsp_data2_q;
    rsp_fwd_d     = rsp_fwd_q;
    r1_hold_d     = r1_hold_q;
    r2_hold_d     = r2_hold_q;
    w_addr_hold_d = w_addr_hold_q;
    w_data_hold_d = w_data_hold_q;

    case (cmd)
      CMD_RD: begin
        prd_valid_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_data1_d = hit1 ? bdata1 : RF_R1_DATA;
        rsp_data2_d = hit2 ? bdata2 : RF_R2_DATA;
        rsp_fwd_d   = {hit2, hit1};
        r1_hold_d   = prd_a1_q;
        r2_hold_d   = prd_a2_q;
      end
      CMD_WR: begin
        w_addr_hold_d = head_addr;
        w_data_hold_d = head_data;
      end
      default: ;
    endcase

    if (rd_fire) begin
      prd_valid_d = 1'b1;
      prd_a1_d    = RD_ADDR1;
      prd_a2_d    = RD_ADDR2;
    end
  end

  assign RF_READ    = (cmd == CMD_RD);
  assign RF_WRITE   = (cmd == CMD_WR);
  assign RF_R1_ADDR = RF_READ  ? prd_a1_q  : r1_hold_q;
  assign RF_R2_ADDR = RF_READ  ? prd_a2_q  : r2_hold_q;
  assign RF_W_ADDR  = RF_WRITE ? head_addr : w_addr_hold_q;
  assign RF_W_DATA  = RF_WRITE ? head_data : w_data_hold_q;

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA1 = rsp_data1_q;
  assign RSP_DATA2 = rsp_data2_q;
  assign RSP_FWD   = rsp_fwd_q;

endmodule
